// File: rtl/demux_pkg.sv
// Shared definitions for the enable-gated BCD-to-decimal select decoder.
// Optional feature macro: DEMUX_1_4_ERR_EN (adds the registered o_err flag).
package demux_pkg;

    // Width of the BCD code presented on {i_d,i_c,i_b,i_a}
    localparam int CODE_W   = 4;
    // Number of decoded one-hot select lines
    localparam int NUM_OUT  = 10;
    // Largest code that maps onto a select line; anything above is non-BCD
    localparam int MAX_CODE = 9;

    // One-hot select vector for a code.
    // Non-BCD codes (10..15) and a deasserted enable both give all-zero.
    function automatic logic [NUM_OUT-1:0] bcd_onehot(
        input logic [CODE_W-1:0] code,
        input logic              en
    );
        logic [NUM_OUT-1:0] vec;
        vec = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            vec[k] = en && (code == CODE_W'(k));
        end
        return vec;
    endfunction

endpackage

// File: rtl/bcd_dec_4_10.sv
// Purely combinational 4-to-10 BCD decode with three-input chip-select
// gating (one active-high, two active-low).
// Optional feature macro: DEMUX_1_4_ERR_EN (adds the invalid-code term err).
module bcd_dec_4_10
    import demux_pkg::*;
(
    input  logic              cs,
    input  logic              n_cs_0,
    input  logic              n_cs_1,
    input  logic [CODE_W-1:0] code,
    output logic [NUM_OUT-1:0] sel
`ifdef DEMUX_1_4_ERR_EN
    ,
    output logic              err
`endif
);

    logic en;

    // Chip is selected only when the high select is asserted and both low selects are asserted
    assign en = cs & ~n_cs_0 & ~n_cs_1;

    // Decode the code into a one-hot select vector, gated by the chip select
    always_comb begin
        sel = bcd_onehot(code, en);
    end

`ifdef DEMUX_1_4_ERR_EN
    // Flag a non-BCD code presented while the chip is selected
    always_comb begin
        err = en & (code > CODE_W'(MAX_CODE));
    end
`endif

endmodule

// File: rtl/demux_1_4.sv
// Top level: registered one-of-ten select decoder with chip-select gating.
// The decode is combinational in bcd_dec_4_10; this level adds the single
// output register stage (async active-high reset) and fans the vector out
// to the individual select pins.
// Optional feature macro: DEMUX_1_4_ERR_EN (adds port o_err).
module demux_1_4
    import demux_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    input  logic i_cs,
    input  logic i_n_cs_0,
    input  logic i_n_cs_1,
    output logic o_0,
    output logic o_1,
    output logic o_2,
    output logic o_3,
    output logic o_4,
    output logic o_5,
    output logic o_6,
    output logic o_7,
    output logic o_8,
    output logic o_9
`ifdef DEMUX_1_4_ERR_EN
    ,
    output logic o_err
`endif
);

    logic [CODE_W-1:0]  code;
    logic [NUM_OUT-1:0] sel_d;
    logic [NUM_OUT-1:0] sel_q;

    assign code = {i_d, i_c, i_b, i_a};

`ifdef DEMUX_1_4_ERR_EN
    logic err_d;
    logic err_q;

    bcd_dec_4_10 u_dec (
        .cs     (i_cs),
        .n_cs_0 (i_n_cs_0),
        .n_cs_1 (i_n_cs_1),
        .code   (code),
        .sel    (sel_d),
        .err    (err_d)
    );

    // Register the error flag alongside the selects so both share latency and reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    bcd_dec_4_10 u_dec (
        .cs     (i_cs),
        .n_cs_0 (i_n_cs_0),
        .n_cs_1 (i_n_cs_1),
        .code   (code),
        .sel    (sel_d)
    );
`endif

    // Capture the decoded selects each edge; reset clears them without waiting for the clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign o_0 = sel_q[0];
    assign o_1 = sel_q[1];
    assign o_2 = sel_q[2];
    assign o_3 = sel_q[3];
    assign o_4 = sel_q[4];
    assign o_5 = sel_q[5];
    assign o_6 = sel_q[6];
    assign o_7 = sel_q[7];
    assign o_8 = sel_q[8];
    assign o_9 = sel_q[9];

endmodule

// File: tb/tb_demux_1_4.sv
// Self-checking bench for demux_1_4: directed reset, sweep, select-gating
// and back-to-back steps followed by a randomized run, all compared against
// a behavioural model of the one-of-ten decode.
// Optional feature macro: DEMUX_1_4_ERR_EN (also checks o_err).
module tb_demux_1_4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_a = 1'b0;
    logic i_b = 1'b0;
    logic i_c = 1'b0;
    logic i_d = 1'b0;
    logic i_cs = 1'b0;
    logic i_n_cs_0 = 1'b1;
    logic i_n_cs_1 = 1'b1;
    logic o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7, o_8, o_9;
    logic o_err_obs;

    logic [9:0] sel_obs;
    logic [9:0] exp_sel;
    logic       exp_err;

    int tests = 0;
    int fails = 0;

    demux_1_4 dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_c      (i_c),
        .i_d      (i_d),
        .i_cs     (i_cs),
        .i_n_cs_0 (i_n_cs_0),
        .i_n_cs_1 (i_n_cs_1),
        .o_0      (o_0),
        .o_1      (o_1),
        .o_2      (o_2),
        .o_3      (o_3),
        .o_4      (o_4),
        .o_5      (o_5),
        .o_6      (o_6),
        .o_7      (o_7),
        .o_8      (o_8),
        .o_9      (o_9)
`ifdef DEMUX_1_4_ERR_EN
        ,
        .o_err    (o_err_obs)
`endif
    );

`ifndef DEMUX_1_4_ERR_EN
    assign o_err_obs = 1'b0;
`endif

    assign sel_obs = {o_9, o_8, o_7, o_6, o_5, o_4, o_3, o_2, o_1, o_0};

    // 10 ns clock
    always #5 i_clk = ~i_clk;

    // Reference: chip selected and code in 0..9 lights exactly that line
    function automatic logic [9:0] model_sel(input logic cs, input logic n0,
                                             input logic n1, input int code);
        logic [9:0] v;
        v = '0;
        if (cs && !n0 && !n1 && code >= 0 && code <= 9) v[code] = 1'b1;
        return v;
    endfunction

    // Reference: chip selected with a code above 9
    function automatic logic model_err(input logic cs, input logic n0,
                                       input logic n1, input int code);
        return cs && !n0 && !n1 && code > 9;
    endfunction

    task automatic apply_stimulus(input logic cs, input logic n0,
                                  input logic n1, input int code);
        logic [3:0] c;
        c = 4'(code);
        i_cs = cs;
        i_n_cs_0 = n0;
        i_n_cs_1 = n1;
        {i_d, i_c, i_b, i_a} = c;
    endtask

    task automatic check_output(input string tag);
        tests++;
        assert (sel_obs === exp_sel) else begin
            fails++;
            $error("FAIL %s sel observed=%b expected=%b", tag, sel_obs, exp_sel);
        end
`ifdef DEMUX_1_4_ERR_EN
        tests++;
        assert (o_err_obs === exp_err) else begin
            fails++;
            $error("FAIL %s_err observed=%b expected=%b", tag, o_err_obs, exp_err);
        end
`endif
    endtask

    // Called at posedge+1: change inputs, confirm outputs hold, then confirm the next edge loads them
    task automatic step(input string tag, input logic cs, input logic n0,
                        input logic n1, input int code);
        apply_stimulus(cs, n0, n1, code);
        #1;
        check_output({tag, "_hold"});
        @(posedge i_clk);
        #1;
        exp_sel = model_sel(cs, n0, n1, code);
        exp_err = model_err(cs, n0, n1, code);
        check_output(tag);
    endtask

    initial begin
        exp_sel = '0;
        exp_err = 1'b0;

        // Reset asserted with chip enabled and code 3: outputs clear at once
        apply_stimulus(1'b1, 1'b0, 1'b0, 3);
        #2;
        i_rst = 1'b1;
        #1;
        check_output("rst_immediate");
        @(posedge i_clk);
        #1;
        check_output("rst_held");

        // Release between edges; the next edge loads o_3
        #3;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        exp_sel = model_sel(1'b1, 1'b0, 1'b0, 3);
        exp_err = 1'b0;
        check_output("rst_release_o3");

        // Mid-operation reset clears without a clock edge, then reloads
        i_rst = 1'b1;
        #1;
        exp_sel = '0;
        exp_err = 1'b0;
        check_output("rst_mid_clear");
        #3;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        exp_sel = model_sel(1'b1, 1'b0, 1'b0, 3);
        check_output("rst_mid_reload");

        // Disabled sweep over every code
        for (int c = 0; c < 16; c++) step($sformatf("dis_%0d", c), 1'b0, 1'b0, 1'b0, c);

        // Enabled sweep over every code, including non-BCD values
        for (int c = 0; c < 16; c++) step($sformatf("en_%0d", c), 1'b1, 1'b0, 1'b0, c);

        // Active-low selects each block the decode
        step("ncs0_blk", 1'b1, 1'b1, 1'b0, 5);
        step("en_5", 1'b1, 1'b0, 1'b0, 5);
        step("ncs1_blk", 1'b1, 1'b0, 1'b1, 5);
        step("ncs_both", 1'b1, 1'b1, 1'b1, 12);

        // Back-to-back codes at the two ends of the BCD range
        step("b2b_0", 1'b1, 1'b0, 1'b0, 0);
        step("b2b_9", 1'b1, 1'b0, 1'b0, 9);
        step("b2b_0b", 1'b1, 1'b0, 1'b0, 0);

        // Randomized run, biased towards the chip being selected
        for (int n = 0; n < 200; n++) begin
            logic cs, n0, n1;
            int   code;
            cs   = ($urandom_range(0, 7) != 0);
            n0   = ($urandom_range(0, 7) == 0);
            n1   = ($urandom_range(0, 7) == 0);
            code = int'($urandom_range(0, 15));
            step($sformatf("rnd_%0d", n), cs, n0, n1, code);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
